// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcodes, register-destination and ALU-op
// encodings, and the control vector produced by control_unit.
package decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  // ALU_FUNCT tells EX to take the operation from the funct field.
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_LUI   = 3'd5;

  typedef enum logic [1:0] {
    IMM_SIGN  = 2'd0,
    IMM_ZERO  = 2'd1,
    IMM_UPPER = 2'd2,
    IMM_JUMP  = 2'd3
  } imm_kind_t;

  // Controls that travel down the pipe into EX and beyond.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch_eq;
    logic       branch_ne;
    logic       jump;
    logic [1:0] reg_dst;
    logic [2:0] alu_op;
  } ex_ctrl_t;

  // Full decode result; uses_rt and imm_kind are consumed inside decode only.
  typedef struct packed {
    ex_ctrl_t  ex;
    logic      uses_rt;
    imm_kind_t imm_kind;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_NOP = '{ex: '0, uses_rt: 1'b0, imm_kind: IMM_SIGN};

endpackage

// File: rtl/decode_stage_control_unit.sv
// Combinational main decoder: opcode in, packed control vector out.
module control_unit
  import decode_stage_pkg::*;
#(
  parameter int NB_OP = 6
) (
  input  logic [NB_OP-1:0]  opcode,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  // Opcode lookup; unknown opcodes fall through as a NOP with no side effects
  always_comb begin
    c = CTRL_NOP;
    case (opcode)
      OP_RTYPE: begin
        c.ex.reg_write = 1'b1;
        c.ex.reg_dst   = REG_DST_RD;
        c.ex.alu_op    = ALU_FUNCT;
        c.uses_rt      = 1'b1;
      end
      OP_LW: begin
        c.ex.reg_write  = 1'b1;
        c.ex.mem_read   = 1'b1;
        c.ex.mem_to_reg = 1'b1;
        c.ex.alu_src    = 1'b1;
      end
      OP_SW: begin
        c.ex.mem_write = 1'b1;
        c.ex.alu_src   = 1'b1;
        c.uses_rt      = 1'b1;
      end
      OP_BEQ: begin
        c.ex.branch_eq = 1'b1;
        c.ex.alu_op    = ALU_SUB;
        c.uses_rt      = 1'b1;
      end
      OP_BNE: begin
        c.ex.branch_ne = 1'b1;
        c.ex.alu_op    = ALU_SUB;
        c.uses_rt      = 1'b1;
      end
      OP_ADDI: begin
        c.ex.reg_write = 1'b1;
        c.ex.alu_src   = 1'b1;
      end
      OP_ANDI: begin
        c.ex.reg_write = 1'b1;
        c.ex.alu_src   = 1'b1;
        c.ex.alu_op    = ALU_AND;
        c.imm_kind     = IMM_ZERO;
      end
      OP_ORI: begin
        c.ex.reg_write = 1'b1;
        c.ex.alu_src   = 1'b1;
        c.ex.alu_op    = ALU_OR;
        c.imm_kind     = IMM_ZERO;
      end
      OP_LUI: begin
        c.ex.reg_write = 1'b1;
        c.ex.alu_src   = 1'b1;
        c.ex.alu_op    = ALU_LUI;
        c.imm_kind     = IMM_UPPER;
      end
      OP_J: begin
        c.ex.jump  = 1'b1;
        c.imm_kind = IMM_JUMP;
      end
      OP_JAL: begin
        c.ex.jump      = 1'b1;
        c.ex.reg_write = 1'b1;
        c.ex.reg_dst   = REG_DST_R31;
        c.imm_kind     = IMM_JUMP;
      end
      default: c = CTRL_NOP;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/decode_stage.sv
// ID stage: decodes the IF/ID instruction, detects load-use hazards,
// applies writeback bypass and fills the ID/EX pipeline register.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_OP   = 6
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [NB_DATA-1:0] instr_i,
  input  logic [NB_DATA-1:0] pc_i,
  input  logic               valid_i,
  output logic [NB_REG-1:0]  addr_ra_o,
  output logic [NB_REG-1:0]  addr_rb_o,
  input  logic [NB_DATA-1:0] data_ra_i,
  input  logic [NB_DATA-1:0] data_rb_i,
  input  logic               wb_rw_i,
  input  logic [NB_REG-1:0]  wb_addr_i,
  input  logic [NB_DATA-1:0] wb_data_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic [NB_DATA-1:0] ex_pc_o,
  output logic [NB_DATA-1:0] ex_data_a_o,
  output logic [NB_DATA-1:0] ex_data_b_o,
  output logic [NB_DATA-1:0] ex_imm_o,
  output logic [NB_REG-1:0]  ex_rs_o,
  output logic [NB_REG-1:0]  ex_rt_o,
  output logic [NB_REG-1:0]  ex_rd_o,
  output logic [NB_OP-1:0]   ex_funct_o,
  output logic [NB_REG-1:0]  ex_shamt_o,
  output logic               ex_reg_write_o,
  output logic               ex_mem_read_o,
  output logic               ex_mem_write_o,
  output logic               ex_mem_to_reg_o,
  output logic               ex_alu_src_o,
  output logic               ex_branch_eq_o,
  output logic               ex_branch_ne_o,
  output logic               ex_jump_o,
  output logic [1:0]         ex_reg_dst_o,
  output logic [2:0]         ex_alu_op_o
);

  localparam logic [NB_REG-1:0] REG_ZERO = '0;

  function automatic logic [NB_DATA-1:0] ext_imm(input imm_kind_t kind,
                                                 input logic [NB_DATA-1:0] instr,
                                                 input logic [NB_DATA-1:0] pc);
    case (kind)
      IMM_ZERO:  return {{(NB_DATA-16){1'b0}}, instr[15:0]};
      IMM_UPPER: return {instr[15:0], {(NB_DATA-16){1'b0}}};
      IMM_JUMP:  return {pc[NB_DATA-1 -: 4], instr[25:0], 2'b00};
      default:   return {{(NB_DATA-16){instr[15]}}, instr[15:0]};
    endcase
  endfunction

  logic [NB_OP-1:0]  opcode;
  logic [CTRL_W-1:0] ctrl_bits;
  ctrl_t             ctrl;
  logic              load_use;
  logic              bubble;

  // ID/EX pipeline register (_p1)
  logic               vld_p1;
  ex_ctrl_t           ex_p1;
  logic [NB_DATA-1:0] pc_p1;
  logic [NB_DATA-1:0] imm_p1;
  logic [NB_REG-1:0]  rs_p1;
  logic [NB_REG-1:0]  rt_p1;
  logic [NB_REG-1:0]  rd_p1;
  logic [NB_OP-1:0]   funct_p1;
  logic [NB_REG-1:0]  shamt_p1;
  logic               byp_a_p1;
  logic               byp_b_p1;
  logic [NB_DATA-1:0] wb_data_p1;
  logic               live_p1;

  assign opcode    = instr_i[31:26];
  assign addr_ra_o = instr_i[25:21];
  assign addr_rb_o = instr_i[20:16];

  control_unit #(.NB_OP(NB_OP)) u_control_unit (
    .opcode(opcode),
    .ctrl  (ctrl_bits)
  );

  assign ctrl = ctrl_t'(ctrl_bits);

  // A load in EX whose destination is read here cannot be forwarded in time.
  // Once the bubble is in EX, vld_p1 drops and the stall releases itself.
  assign load_use = valid_i && vld_p1 && ex_p1.mem_read && (rt_p1 != REG_ZERO) &&
                    ((rt_p1 == addr_ra_o) || (ctrl.uses_rt && (rt_p1 == addr_rb_o)));
  assign stall_o  = reset_i && !flush_i && load_use;
  assign bubble   = !valid_i || flush_i || load_use;

  // ID/EX register: controls zeroed on bubbles; bypass captures a same-edge writeback
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      vld_p1     <= 1'b0;
      ex_p1      <= '0;
      pc_p1      <= '0;
      imm_p1     <= '0;
      rs_p1      <= '0;
      rt_p1      <= '0;
      rd_p1      <= '0;
      funct_p1   <= '0;
      shamt_p1   <= '0;
      byp_a_p1   <= 1'b0;
      byp_b_p1   <= 1'b0;
      wb_data_p1 <= '0;
      live_p1    <= 1'b0;
    end else begin
      vld_p1     <= !bubble;
      ex_p1      <= bubble ? ex_ctrl_t'('0) : ctrl.ex;
      pc_p1      <= pc_i;
      imm_p1     <= ext_imm(ctrl.imm_kind, instr_i, pc_i);
      rs_p1      <= addr_ra_o;
      rt_p1      <= addr_rb_o;
      rd_p1      <= instr_i[15:11];
      funct_p1   <= instr_i[5:0];
      shamt_p1   <= instr_i[10:6];
      byp_a_p1   <= wb_rw_i && (wb_addr_i != REG_ZERO) && (wb_addr_i == addr_ra_o);
      byp_b_p1   <= wb_rw_i && (wb_addr_i != REG_ZERO) && (wb_addr_i == addr_rb_o);
      wb_data_p1 <= wb_data_i;
      live_p1    <= 1'b1;
    end
  end

  // Operand data arrives from the bank in the ID/EX cycle; live_p1 holds it at zero after reset
  assign ex_data_a_o = !live_p1 ? '0 : (byp_a_p1 ? wb_data_p1 : data_ra_i);
  assign ex_data_b_o = !live_p1 ? '0 : (byp_b_p1 ? wb_data_p1 : data_rb_i);

  assign ex_valid_o      = vld_p1;
  assign ex_pc_o         = pc_p1;
  assign ex_imm_o        = imm_p1;
  assign ex_rs_o         = rs_p1;
  assign ex_rt_o         = rt_p1;
  assign ex_rd_o         = rd_p1;
  assign ex_funct_o      = funct_p1;
  assign ex_shamt_o      = shamt_p1;
  assign ex_reg_write_o  = ex_p1.reg_write;
  assign ex_mem_read_o   = ex_p1.mem_read;
  assign ex_mem_write_o  = ex_p1.mem_write;
  assign ex_mem_to_reg_o = ex_p1.mem_to_reg;
  assign ex_alu_src_o    = ex_p1.alu_src;
  assign ex_branch_eq_o  = ex_p1.branch_eq;
  assign ex_branch_ne_o  = ex_p1.branch_ne;
  assign ex_jump_o       = ex_p1.jump;
  assign ex_reg_dst_o    = ex_p1.reg_dst;
  assign ex_alu_op_o     = ex_p1.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: register-bank model, directed instruction
// sequence, and a scoreboard of expected ID/EX contents.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset_i;
  logic [31:0] instr_i, pc_i;
  logic        valid_i, flush_i;
  logic [4:0]  addr_ra_o, addr_rb_o;
  logic [31:0] data_ra_i, data_rb_i;
  logic        wb_rw_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        stall_o, ex_valid_o;
  logic [31:0] ex_pc_o, ex_data_a_o, ex_data_b_o, ex_imm_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o, ex_shamt_o;
  logic [5:0]  ex_funct_o;
  logic        ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o;
  logic        ex_alu_src_o, ex_branch_eq_o, ex_branch_ne_o, ex_jump_o;
  logic [1:0]  ex_reg_dst_o;
  logic [2:0]  ex_alu_op_o;

  decode_stage dut (
    .clock_i(clock), .reset_i(reset_i), .instr_i(instr_i), .pc_i(pc_i), .valid_i(valid_i),
    .addr_ra_o(addr_ra_o), .addr_rb_o(addr_rb_o), .data_ra_i(data_ra_i), .data_rb_i(data_rb_i),
    .wb_rw_i(wb_rw_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .flush_i(flush_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_data_a_o(ex_data_a_o),
    .ex_data_b_o(ex_data_b_o), .ex_imm_o(ex_imm_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o),
    .ex_rd_o(ex_rd_o), .ex_funct_o(ex_funct_o), .ex_shamt_o(ex_shamt_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
    .ex_mem_write_o(ex_mem_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
    .ex_alu_src_o(ex_alu_src_o), .ex_branch_eq_o(ex_branch_eq_o),
    .ex_branch_ne_o(ex_branch_ne_o), .ex_jump_o(ex_jump_o), .ex_reg_dst_o(ex_reg_dst_o),
    .ex_alu_op_o(ex_alu_op_o)
  );

  always #5 clock = ~clock;

  // Register bank: read data registered one cycle after the address, read-before-write
  logic [31:0] regs [32];
  always @(posedge clock) begin
    if (!reset_i) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : (32'hA000_0000 | 32'(i));
    end else begin
      data_ra_i <= regs[addr_ra_o];
      data_rb_i <= regs[addr_rb_o];
      if (wb_rw_i && wb_addr_i != 5'd0) regs[wb_addr_i] <= wb_data_i;
    end
  end

  // ctl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch_eq, branch_ne, jump}
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [7:0]  ctl;
    logic [1:0]  reg_dst;
    logic [2:0]  alu_op;
    logic [31:0] da, db;
  } idex_t;

  idex_t       sb[$];
  idex_t       cur;
  logic [31:0] pcv;
  int          total = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic idex_t observe();
    idex_t o;
    o.valid = ex_valid_o; o.pc = ex_pc_o; o.imm = ex_imm_o;
    o.rs = ex_rs_o; o.rt = ex_rt_o; o.rd = ex_rd_o; o.funct = ex_funct_o; o.shamt = ex_shamt_o;
    o.ctl = {ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o,
             ex_alu_src_o, ex_branch_eq_o, ex_branch_ne_o, ex_jump_o};
    o.reg_dst = ex_reg_dst_o; o.alu_op = ex_alu_op_o; o.da = ex_data_a_o; o.db = ex_data_b_o;
    return o;
  endfunction

  // Reference decode of one accepted instruction
  function automatic idex_t model(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] da, input logic [31:0] db);
    idex_t m;
    m = '0;
    m.valid = 1'b1; m.pc = pc; m.da = da; m.db = db;
    m.rs = ins[25:21]; m.rt = ins[20:16]; m.rd = ins[15:11];
    m.funct = ins[5:0]; m.shamt = ins[10:6];
    m.imm = {{16{ins[15]}}, ins[15:0]};
    m.reg_dst = REG_DST_RT; m.alu_op = ALU_ADD;
    case (ins[31:26])
      6'h00: begin m.ctl = 8'b1000_0000; m.reg_dst = REG_DST_RD; m.alu_op = ALU_FUNCT; end
      6'h23: m.ctl = 8'b1101_1000;
      6'h2B: m.ctl = 8'b0010_1000;
      6'h04: begin m.ctl = 8'b0000_0100; m.alu_op = ALU_SUB; end
      6'h05: begin m.ctl = 8'b0000_0010; m.alu_op = ALU_SUB; end
      6'h08: m.ctl = 8'b1000_1000;
      6'h0C: begin m.ctl = 8'b1000_1000; m.alu_op = ALU_AND; m.imm = {16'h0, ins[15:0]}; end
      6'h0D: begin m.ctl = 8'b1000_1000; m.alu_op = ALU_OR;  m.imm = {16'h0, ins[15:0]}; end
      6'h0F: begin m.ctl = 8'b1000_1000; m.alu_op = ALU_LUI; m.imm = {ins[15:0], 16'h0}; end
      6'h02: begin m.ctl = 8'b0000_0001; m.imm = {pc[31:28], ins[25:0], 2'b00}; end
      6'h03: begin
        m.ctl = 8'b1000_0001; m.reg_dst = REG_DST_R31; m.imm = {pc[31:28], ins[25:0], 2'b00};
      end
      default: ;
    endcase
    return m;
  endfunction

  // One decode cycle: drive, check stall, push expectation, clock, pop and compare
  task automatic cycle(input string tag, input logic [31:0] ins, input logic v, input logic fl,
                       input logic wr, input logic [4:0] wa, input logic [31:0] wd);
    idex_t       e, o;
    logic        es, ut;
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [31:0] da, db;
    instr_i = ins; pc_i = pcv; valid_i = v; flush_i = fl;
    wb_rw_i = wr; wb_addr_i = wa; wb_data_i = wd;
    #1;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    ut = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
    es = v && !fl && cur.valid && cur.ctl[6] && (cur.rt != 5'd0) &&
         ((cur.rt == rs) || (ut && cur.rt == rt));
    chk({tag, ".stall"}, stall_o, es);
    da = (wr && wa != 5'd0 && wa == rs) ? wd : regs[rs];
    db = (wr && wa != 5'd0 && wa == rt) ? wd : regs[rt];
    if (v && !fl && !es) e = model(ins, pcv, da, db);
    else begin
      e = '0; e.da = da; e.db = db;
    end
    sb.push_back(e);
    pcv = pcv + 32'd4;
    @(posedge clock); #1;
    e = sb.pop_front();
    o = observe();
    if (e.valid) chk({tag, ".idex"}, o, e);
    else chk({tag, ".bubble"}, {o.valid, o.ctl, o.da, o.db}, {e.valid, e.ctl, e.da, e.db});
    cur = e;
  endtask

  logic [31:0] lw8, add8;

  initial begin
    pcv = 32'hB000_0000;
    cur = '0;
    lw8  = itype(6'h23, 5'd9, 5'd8, 16'd4);
    add8 = rtype(5'd8, 5'd11, 5'd10, 6'h20);
    reset_i = 1'b0; instr_i = lw8; pc_i = 32'h0; valid_i = 1'b1; flush_i = 1'b0;
    wb_rw_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'h0;
    repeat (3) begin
      @(posedge clock); #1;
      chk("rst.idex", observe(), '0);
      chk("rst.stall", stall_o, 1'b0);
    end
    reset_i = 1'b1;

    cycle("addi", itype(6'h08, 5'd0, 5'd3, 16'h8001), 1, 0, 0, 5'd0, 32'h0);
    chk("addi.imm", ex_imm_o, 32'hFFFF_8001);
    cycle("ori", itype(6'h0D, 5'd0, 5'd3, 16'h8001), 1, 0, 0, 5'd0, 32'h0);
    chk("ori.imm", ex_imm_o, 32'h0000_8001);
    cycle("lui", itype(6'h0F, 5'd0, 5'd3, 16'h1234), 1, 0, 0, 5'd0, 32'h0);
    chk("lui.imm", ex_imm_o, 32'h1234_0000);
    cycle("andi", itype(6'h0C, 5'd1, 5'd2, 16'hF00F), 1, 0, 0, 5'd0, 32'h0);

    cycle("lw8", lw8, 1, 0, 0, 5'd0, 32'h0);
    cycle("add.hz", add8, 1, 0, 0, 5'd0, 32'h0);
    chk("add.hz.vld", ex_valid_o, 1'b0);
    cycle("add.go", add8, 1, 0, 0, 5'd0, 32'h0);
    chk("add.go.rs", ex_rs_o, 5'd8);

    cycle("lw0", itype(6'h23, 5'd1, 5'd0, 16'd0), 1, 0, 0, 5'd0, 32'h0);
    cycle("add0", rtype(5'd0, 5'd3, 5'd2, 6'h20), 1, 0, 0, 5'd0, 32'h0);
    cycle("lw8b", lw8, 1, 0, 0, 5'd0, 32'h0);
    cycle("addi.rb", itype(6'h08, 5'd1, 5'd8, 16'd7), 1, 0, 0, 5'd0, 32'h0);
    cycle("lw8c", lw8, 1, 0, 0, 5'd0, 32'h0);
    cycle("sw.hz", itype(6'h2B, 5'd1, 5'd8, 16'd0), 1, 0, 0, 5'd0, 32'h0);
    cycle("sw.go", itype(6'h2B, 5'd1, 5'd8, 16'd0), 1, 0, 0, 5'd0, 32'h0);

    cycle("byp", rtype(5'd5, 5'd5, 5'd1, 6'h20), 1, 0, 1, 5'd5, 32'hDEAD_BEEF);
    chk("byp.a", ex_data_a_o, 32'hDEAD_BEEF);
    chk("byp.b", ex_data_b_o, 32'hDEAD_BEEF);
    cycle("byp0", rtype(5'd0, 5'd0, 5'd1, 6'h20), 1, 0, 1, 5'd0, 32'h1234_5678);
    chk("byp0.a", ex_data_a_o, 32'h0);
    cycle("rd5", rtype(5'd5, 5'd2, 5'd1, 6'h22), 1, 0, 0, 5'd0, 32'h0);

    cycle("lw8d", lw8, 1, 0, 0, 5'd0, 32'h0);
    cycle("flush", add8, 1, 1, 0, 5'd0, 32'h0);
    chk("flush.vld", ex_valid_o, 1'b0);

    cycle("beq", itype(6'h04, 5'd1, 5'd2, 16'hFFFE), 1, 0, 0, 5'd0, 32'h0);
    cycle("bne", itype(6'h05, 5'd3, 5'd4, 16'h0010), 1, 0, 0, 5'd0, 32'h0);
    cycle("j", {6'h02, 26'h123_4567}, 1, 0, 0, 5'd0, 32'h0);
    cycle("jal", {6'h03, 26'h2AB_CDEF}, 1, 0, 0, 5'd0, 32'h0);
    chk("jal.imm", ex_imm_o, {4'hB, 26'h2AB_CDEF, 2'b00});
    cycle("unk", itype(6'h3F, 5'd1, 5'd2, 16'h0003), 1, 0, 0, 5'd0, 32'h0);
    cycle("novld", add8, 0, 0, 0, 5'd0, 32'h0);

    // Reset arriving while a load-use stall is pending
    cycle("lw8e", lw8, 1, 0, 0, 5'd0, 32'h0);
    instr_i = add8; valid_i = 1'b1; flush_i = 1'b0; wb_rw_i = 1'b0; reset_i = 1'b0;
    #1;
    chk("mrst.stall", stall_o, 1'b0);
    @(posedge clock); #1;
    chk("mrst.idex", observe(), '0);
    reset_i = 1'b1;
    cur = '0;
    cycle("post", itype(6'h08, 5'd2, 5'd6, 16'h0042), 1, 0, 0, 5'd0, 32'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
